// File: rtl/exec_unit_mc_if.sv
// ---------------------------------------------------------------------------
// exec_unit_mc_if
//   Issue bus between decode and the execute stage. Signal names carry the
//   direction as seen from the execute unit (i_ = into the unit, o_ = out).
//
//   i_valid    decode presents an operation
//   o_ready    execute unit can accept (handshake = i_valid & o_ready)
//   i_opcode   4-bit operation code
//   i_src1     operand 1
//   i_src2     operand 2 / shift amount
//   i_destadd  destination register address
//
//   Modports: master = decode side, slave = execute unit.
// ---------------------------------------------------------------------------
interface exec_unit_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              i_valid;
  logic              o_ready;
  logic [3:0]        i_opcode;
  logic [DATA_W-1:0] i_src1;
  logic [DATA_W-1:0] i_src2;
  logic [ADDR_W-1:0] i_destadd;

  modport master (
    output i_valid, i_opcode, i_src1, i_src2, i_destadd,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_opcode, i_src1, i_src2, i_destadd,
    output o_ready
  );

endinterface

// File: rtl/exec_unit_mc.sv
// ---------------------------------------------------------------------------
// exec_unit_mc
//   Execute stage of the FDE CPU. Accepts one operation per issue handshake,
//   runs single-cycle ALU ops directly from IDLE, and iterates shifts (one bit
//   per cycle) and multiplies (shift-add, DATA_W steps) in dedicated states.
//   Every completed write-type op produces a one-cycle register-file write
//   strobe together with zero/carry flags; undefined opcodes produce a
//   one-cycle o_illegal pulse instead.
//
//   i_clk         clock, rising edge
//   i_reset       asynchronous, active-low reset
//   if_issue      issue bus (valid/ready, opcode, operands, destination)
//   o_write_en    one-cycle write strobe to the register file
//   o_write_add   write address, held between strobes
//   o_write_data  write data, held between strobes
//   o_carry       carry/borrow/overflow of the last written result
//   o_zero        1 when the last written result was zero
//   o_illegal     one-cycle pulse: undefined opcode accepted
// ---------------------------------------------------------------------------
module exec_unit_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  exec_unit_mc_if.slave     if_issue,
  output logic              o_write_en,
  output logic [ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_illegal
);

  localparam int SHAMT_W = $clog2(DATA_W);
  // One extra bit so the counter can hold DATA_W for the multiply.
  localparam int CNT_W   = SHAMT_W + 1;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_shift_left;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_W-1:0]     r_dest;
  logic [DATA_W-1:0]     r_mcand;
  // Shift work value lives in the low half; the multiply uses all of it as
  // {partial product, remaining multiplier bits}.
  logic [2*DATA_W-1:0]   r_acc;

  logic                  w_accept;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_alu_write;
  logic                  w_alu_illegal;
  logic                  w_start_shift;
  logic                  w_start_mul;
  logic [DATA_W-1:0]     w_alu_data;
  logic                  w_alu_carry;
  logic [DATA_W-1:0]     w_shift_next;
  logic                  w_shift_out;
  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_next;

  // o_ready is a registered copy of "FSM in IDLE"; it resets low so the unit
  // first advertises ready one cycle after reset release.
  assign if_issue.o_ready = r_ready;
  assign w_accept         = if_issue.i_valid & r_ready;
  assign w_shamt          = if_issue.i_src2[SHAMT_W-1:0];

  // -------------------------------------------------------------------------
  // Decode of the presented operation (only meaningful on accept).
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    w_alu_write   = 1'b0;
    w_alu_illegal = 1'b0;
    w_start_shift = 1'b0;
    w_start_mul   = 1'b0;
    w_alu_data    = '0;
    w_alu_carry   = 1'b0;

    case (if_issue.i_opcode)
      OP_NOP: ;
      OP_ADD: begin
        {w_alu_carry, w_alu_data} = {1'b0, if_issue.i_src1} + {1'b0, if_issue.i_src2};
        w_alu_write = 1'b1;
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is the borrow (src1 < src2).
        {w_alu_carry, w_alu_data} = {1'b0, if_issue.i_src1} - {1'b0, if_issue.i_src2};
        w_alu_write = 1'b1;
      end
      OP_AND: begin
        w_alu_data  = if_issue.i_src1 & if_issue.i_src2;
        w_alu_write = 1'b1;
      end
      OP_OR: begin
        w_alu_data  = if_issue.i_src1 | if_issue.i_src2;
        w_alu_write = 1'b1;
      end
      OP_XOR: begin
        w_alu_data  = if_issue.i_src1 ^ if_issue.i_src2;
        w_alu_write = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        // A zero-amount shift is a plain pass-through with carry 0 and
        // completes at single-cycle latency.
        if (w_shamt == '0) begin
          w_alu_data  = if_issue.i_src1;
          w_alu_write = 1'b1;
        end else begin
          w_start_shift = 1'b1;
        end
      end
      OP_MUL:  w_start_mul   = 1'b1;
      default: w_alu_illegal = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // One iteration step for the multi-cycle states.
  // -------------------------------------------------------------------------
  always_comb begin
    w_shift_next = '0;
    w_shift_out  = 1'b0;
    if (r_shift_left) begin
      w_shift_next = {r_acc[DATA_W-2:0], 1'b0};
      w_shift_out  = r_acc[DATA_W-1];
    end else begin
      w_shift_next = {1'b0, r_acc[DATA_W-1:1]};
      w_shift_out  = r_acc[0];
    end

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
               + (r_acc[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_shift_left <= 1'b0;
      r_count      <= '0;
      r_dest       <= '0;
      r_mcand      <= '0;
      r_acc        <= '0;
      o_write_en   <= 1'b0;
      o_write_add  <= '0;
      o_write_data <= '0;
      o_carry      <= 1'b0;
      o_zero       <= 1'b0;
      o_illegal    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values; the strobes below default low and are overridden
      // only in the cycle that completes an operation.
      o_write_en <= 1'b0;
      o_illegal  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_dest <= if_issue.i_destadd;
            if (w_alu_write) begin
              o_write_en   <= 1'b1;
              o_write_add  <= if_issue.i_destadd;
              o_write_data <= w_alu_data;
              o_carry      <= w_alu_carry;
              o_zero       <= (w_alu_data == '0);
            end
            if (w_alu_illegal) begin
              o_illegal <= 1'b1;
            end
            if (w_start_shift) begin
              r_state      <= S_SHIFT;
              r_ready      <= 1'b0;
              r_shift_left <= (if_issue.i_opcode == OP_SHL);
              r_count      <= {1'b0, w_shamt};
              r_acc        <= {{DATA_W{1'b0}}, if_issue.i_src1};
            end
            if (w_start_mul) begin
              r_state <= S_MUL;
              r_ready <= 1'b0;
              r_count <= CNT_W'(DATA_W);
              r_mcand <= if_issue.i_src1;
              r_acc   <= {{DATA_W{1'b0}}, if_issue.i_src2};
            end
          end
        end

        S_SHIFT: begin
          r_acc[DATA_W-1:0] <= w_shift_next;
          r_count           <= r_count - CNT_W'(1);
          // Final step: write in the same cycle the FSM re-enters IDLE.
          if (r_count == CNT_W'(1)) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            o_write_en   <= 1'b1;
            o_write_add  <= r_dest;
            o_write_data <= w_shift_next;
            o_carry      <= w_shift_out;
            o_zero       <= (w_shift_next == '0);
          end
        end

        S_MUL: begin
          r_acc   <= w_mul_next;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            o_write_en   <= 1'b1;
            o_write_add  <= r_dest;
            o_write_data <= w_mul_next[DATA_W-1:0];
            o_carry      <= |w_mul_next[2*DATA_W-1:DATA_W];
            o_zero       <= (w_mul_next[DATA_W-1:0] == '0);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_exec_unit_mc
//   Self-checking bench for exec_unit_mc (DATA_W=8, ADDR_W=4). A transaction
//   model predicts, for each accepted operation, the result, flags and the
//   cycle in which the write (or illegal pulse) must appear, plus when the
//   unit is busy. Every cycle all outputs are compared against the model.
//   Directed cases are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_exec_unit_mc;

  localparam int W = 8;
  localparam int A = 4;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         o_write_en;
  logic [A-1:0] o_write_add;
  logic [W-1:0] o_write_data;
  logic         o_carry;
  logic         o_zero;
  logic         o_illegal;

  always #5 i_clk = ~i_clk;

  exec_unit_mc_if #(.DATA_W(W), .ADDR_W(A)) bus ();

  exec_unit_mc #(.DATA_W(W), .ADDR_W(A)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .if_issue     (bus),
    .o_write_en   (o_write_en),
    .o_write_add  (o_write_add),
    .o_write_data (o_write_data),
    .o_carry      (o_carry),
    .o_zero       (o_zero),
    .o_illegal    (o_illegal)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [W-1:0] data;
    logic [A-1:0] add;
    logic         carry;
    logic         zero;
  } wr_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;          // number of rising edges seen
  int  busy_until = 0;   // unit ready again once cyc >= busy_until
  bit  in_reset = 1'b1;
  wr_t ev_wr [int];      // expected write, keyed by cycle
  bit  ev_ill [int];     // expected illegal pulse, keyed by cycle

  logic [A-1:0] m_add   = '0;
  logic [W-1:0] m_data  = '0;
  logic         m_carry = 1'b0;
  logic         m_zero  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on the operands.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output bit wr, output bit ill, output int lat,
                                 output logic [W-1:0] data, output logic carry);
    longint x, y, r;
    int n;
    x = longint'(a);
    y = longint'(b);
    n = int'(b) % W;
    r = 0; wr = 1'b1; ill = 1'b0; lat = 0; carry = 1'b0;
    case (op)
      4'h0: wr = 1'b0;
      4'h1: begin r = x + y; carry = ((r >> W) != 0); end
      4'h2: begin r = x - y; carry = (x < y); end
      4'h3: r = x & y;
      4'h5: r = x | y;
      4'h6: r = x ^ y;
      4'h4: begin r = x << n; carry = (n != 0) && (((x >> (W - n)) & 1) != 0); lat = n; end
      4'h8: begin r = x >> n; carry = (n != 0) && (((x >> (n - 1)) & 1) != 0); lat = n; end
      4'h9: begin r = x * y; carry = ((r >> W) != 0); lat = W; end
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    data = r[W-1:0];
  endfunction

  task automatic check_outputs();
    bit exp_we, exp_ill, exp_rdy;
    exp_we = ev_wr.exists(cyc);
    if (exp_we) begin
      m_add   = ev_wr[cyc].add;
      m_data  = ev_wr[cyc].data;
      m_carry = ev_wr[cyc].carry;
      m_zero  = ev_wr[cyc].zero;
      ev_wr.delete(cyc);
    end
    exp_ill = ev_ill.exists(cyc);
    if (exp_ill) ev_ill.delete(cyc);
    exp_rdy = !in_reset && (cyc >= busy_until);
    check("write_en",   32'(o_write_en),   32'(exp_we));
    check("write_add",  32'(o_write_add),  32'(m_add));
    check("write_data", 32'(o_write_data), 32'(m_data));
    check("carry",      32'(o_carry),      32'(m_carry));
    check("zero",       32'(o_zero),       32'(m_zero));
    check("illegal",    32'(o_illegal),    32'(exp_ill));
    check("ready",      32'(bus.o_ready),  32'(exp_rdy));
  endtask

  task automatic tick();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    check_outputs();
  endtask

  // Present one cycle of issue-bus stimulus; a_cyc is the edge that accepts it.
  task automatic drive(input bit v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [A-1:0] d,
                       output bit acc, output int a_cyc);
    bit wr, ill;
    int lat;
    logic [W-1:0] data;
    logic carry;
    wr_t e;
    bus.i_valid   = v;
    bus.i_opcode  = op;
    bus.i_src1    = a;
    bus.i_src2    = b;
    bus.i_destadd = d;
    acc   = v && !in_reset && (cyc >= busy_until);
    a_cyc = cyc + 1;
    if (acc) begin
      ref_op(op, a, b, wr, ill, lat, data, carry);
      if (ill) ev_ill[a_cyc] = 1'b1;
      if (wr) begin
        e.data = data; e.add = d; e.carry = carry; e.zero = (data == '0);
        ev_wr[a_cyc + lat] = e;
        if (lat > 0) busy_until = a_cyc + lat;
      end
    end
    tick();
    // Inputs are don't-care after accept: scramble them.
    bus.i_valid   = 1'b0;
    bus.i_opcode  = 4'($urandom);
    bus.i_src1    = W'($urandom);
    bus.i_src2    = W'($urandom);
    bus.i_destadd = A'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [A-1:0] d, output int a_cyc);
    bit acc;
    a_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, op, a, b, d, acc, a_cyc);
      if (acc) return;
    end
    check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_write(output int w_cyc);
    for (int i = 0; i < 40; i++) begin
      if (o_write_en === 1'b1) begin
        w_cyc = cyc;
        return;
      end
      tick();
    end
    check("write_timeout", 32'd0, 32'd1);
    w_cyc = cyc;
  endtask

  task automatic apply_reset(input int cycles);
    i_reset  = 1'b0;
    in_reset = 1'b1;
    bus.i_valid = 1'b0;
    ev_wr.delete();
    ev_ill.delete();
    m_add = '0; m_data = '0; m_carry = 1'b0; m_zero = 1'b0;
    #1;
    check("rst_write_en",   32'(o_write_en),   32'd0);
    check("rst_write_add",  32'(o_write_add),  32'd0);
    check("rst_write_data", 32'(o_write_data), 32'd0);
    check("rst_carry",      32'(o_carry),      32'd0);
    check("rst_zero",       32'(o_zero),       32'd0);
    check("rst_illegal",    32'(o_illegal),    32'd0);
    for (int i = 0; i < cycles; i++) tick();
    i_reset    = 1'b1;
    in_reset   = 1'b0;
    busy_until = cyc + 1;
    check("ready_low_at_release", 32'(bus.o_ready), 32'd0);
    tick();
  endtask

  initial begin
    int a, w;
    bit acc, hold, v;
    logic [3:0] op;
    logic [W-1:0] s1, s2;
    logic [A-1:0] d;

    bus.i_valid = 1'b0; bus.i_opcode = '0; bus.i_src1 = '0; bus.i_src2 = '0; bus.i_destadd = '0;
    @(negedge i_clk);
    apply_reset(2);

    // 1. ADD F0+20 -> 10, carry, latency 1, strobe drops next cycle
    issue(4'h1, 8'hF0, 8'h20, 4'd3, a);
    wait_write(w);
    check("t1_latency", 32'(w - a + 1), 32'd1);
    check("t1_add",     32'(o_write_add),  32'h3);
    check("t1_data",    32'(o_write_data), 32'h10);
    check("t1_carry",   32'(o_carry), 32'd1);
    check("t1_zero",    32'(o_zero),  32'd0);
    tick();
    check("t1_we_drop", 32'(o_write_en), 32'd0);

    // 2. SUB with zero result, then with borrow
    issue(4'h2, 8'h05, 8'h05, 4'd1, a);
    wait_write(w);
    check("t2_data0", 32'(o_write_data), 32'h00);
    check("t2_zero",  32'(o_zero), 32'd1);
    issue(4'h2, 8'h03, 8'h05, 4'd2, a);
    wait_write(w);
    check("t2_dataFE", 32'(o_write_data), 32'hFE);
    check("t2_borrow", 32'(o_carry), 32'd1);

    // 3. SHL 81 by 3 (busy 3 cycles, write at cycle 4), SHR 81 by 1
    issue(4'h4, 8'h81, 8'h03, 4'd4, a);
    check("t3_busy", 32'(bus.o_ready), 32'd0);
    wait_write(w);
    check("t3_latency", 32'(w - a + 1), 32'd4);
    check("t3_data",    32'(o_write_data), 32'h08);
    check("t3_carry",   32'(o_carry), 32'd0);
    check("t3_ready",   32'(bus.o_ready), 32'd1);
    issue(4'h8, 8'h81, 8'h01, 4'd5, a);
    wait_write(w);
    check("t3_shr_data",  32'(o_write_data), 32'h40);
    check("t3_shr_carry", 32'(o_carry), 32'd1);

    // 4. MUL 0D*0B (latency 9), MUL 10*10 overflow to zero
    issue(4'h9, 8'h0D, 8'h0B, 4'd6, a);
    wait_write(w);
    check("t4_latency", 32'(w - a + 1), 32'd9);
    check("t4_data",    32'(o_write_data), 32'h8F);
    check("t4_carry",   32'(o_carry), 32'd0);
    issue(4'h9, 8'h10, 8'h10, 4'd7, a);
    wait_write(w);
    check("t4_ovf_data",  32'(o_write_data), 32'h00);
    check("t4_ovf_carry", 32'(o_carry), 32'd1);
    check("t4_ovf_zero",  32'(o_zero), 32'd1);
    tick();

    // 5. back-to-back ADD, XOR, NOP, illegal
    drive(1'b1, 4'h1, 8'h11, 8'h22, 4'd8, acc, a);
    check("t5_add_we", 32'(o_write_en), 32'd1);
    drive(1'b1, 4'h6, 8'hF0, 8'h0F, 4'd9, acc, a);
    check("t5_xor_we",   32'(o_write_en), 32'd1);
    check("t5_xor_data", 32'(o_write_data), 32'hFF);
    drive(1'b1, 4'h0, 8'h01, 8'h01, 4'd10, acc, a);
    check("t5_nop_we", 32'(o_write_en), 32'd0);
    drive(1'b1, 4'hF, 8'h01, 8'h01, 4'd11, acc, a);
    check("t5_ill_pulse", 32'(o_illegal), 32'd1);
    check("t5_ill_we",    32'(o_write_en), 32'd0);
    tick();
    check("t5_ill_drop", 32'(o_illegal), 32'd0);

    // 6. reset during MUL iteration 4, then ADD 01+01
    issue(4'h9, 8'hFF, 8'hFF, 4'd12, a);
    for (int i = 0; i < 3; i++) tick();
    apply_reset(2);
    for (int i = 0; i < 12; i++) tick();
    issue(4'h1, 8'h01, 8'h01, 4'd13, a);
    wait_write(w);
    check("t6_latency", 32'(w - a + 1), 32'd1);
    check("t6_data",    32'(o_write_data), 32'h02);

    // Randomized traffic; an unaccepted request is held until taken.
    hold = 1'b0; v = 1'b0; op = '0; s1 = '0; s2 = '0; d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        op = 4'($urandom_range(0, 15));
        s1 = W'($urandom);
        s2 = W'($urandom);
        d  = A'($urandom);
        v  = ($urandom_range(0, 3) != 0);
      end
      drive(v, op, s1, s2, d, acc, a);
      hold = v && !acc;
    end
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
